// File: rtl/riscv_pkg.sv
// riscv_pkg: opcodes, NOP encoding and fetch state shared by the pipeline stages
package riscv_pkg;
  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] BR     = 7'b1100011;
  localparam logic [6:0] HALT   = 7'b1111111;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  typedef enum logic {RUN, HALTED} fetch_state_t;
endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: instruction-memory bus and IF/ID register outputs of the fetch stage
interface if_stage_if #(
  parameter int PC_W  = 9,
  parameter int INS_W = 32
);
  logic [PC_W-1:0]  imem_addr;
  logic [INS_W-1:0] imem_rdata;
  logic [PC_W-1:0]  if_id_pc;
  logic [INS_W-1:0] if_id_instr;
  logic             if_id_valid;
  modport master (output imem_addr, input imem_rdata, output if_id_pc, output if_id_instr, output if_id_valid);
  modport slave  (input imem_addr, output imem_rdata, input if_id_pc, input if_id_instr, input if_id_valid);
endinterface

// File: rtl/if_stage.sv
// if_stage: PC register, IF/ID pipeline register, stall/flush handling and halt latch
module if_stage
  import riscv_pkg::*;
#(
  parameter int             PC_W     = 9,
  parameter int             INS_W    = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            id_halt,
  output logic            halted,
  if_stage_if.master      bus
);
  fetch_state_t     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d, if_id_pc_q, if_id_pc_d;
  logic [INS_W-1:0] instr_q, instr_d;
  logic             valid_q, valid_d;
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_id_pc_d = if_id_pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    if (state_q == RUN) begin
      if (branch_taken || id_halt) begin
        // a taken branch is older than the HALT in ID, so it wins and flushes it
        state_d    = branch_taken ? RUN : HALTED;
        pc_d       = branch_taken ? {branch_target[PC_W-1:2], 2'b00} : pc_q;
        if_id_pc_d = '0;
        instr_d    = NOP_INSTR;
        valid_d    = 1'b0;
      end else if (!stall) begin
        pc_d       = pc_q + PC_W'(4);
        if_id_pc_d = pc_q;
        instr_d    = bus.imem_rdata;
        valid_d    = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      if_id_pc_q <= '0;
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_id_pc_q <= if_id_pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end
  assign bus.imem_addr   = pc_q;
  assign bus.if_id_pc    = if_id_pc_q;
  assign bus.if_id_instr = instr_q;
  assign bus.if_id_valid = valid_q;
  assign halted          = (state_q == HALTED);
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed fetch-stage scenarios checked against a queue of expected states
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h00000013;
  logic clk = 0, reset = 1, reset2 = 1;
  logic stall = 0, branch_taken = 0, id_halt = 0;
  logic [8:0] branch_target = '0;
  logic halted, halted2;
  logic [31:0] mem [128];
  int errors = 0, checks = 0;
  typedef struct {
    bit          sel;
    string       tag;
    logic [8:0]  pc, ifpc;
    logic [31:0] instr;
    logic        valid, halt;
  } exp_t;
  exp_t sb[$];

  if_stage_if #(.PC_W(9), .INS_W(32)) bus ();
  if_stage_if #(.PC_W(9), .INS_W(32)) bus2 ();
  assign bus.imem_rdata  = mem[bus.imem_addr[8:2]];
  assign bus2.imem_rdata = mem[bus2.imem_addr[8:2]];

  if_stage #(.PC_W(9), .INS_W(32), .RESET_PC(9'h000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .id_halt(id_halt), .halted(halted), .bus(bus));
  if_stage #(.PC_W(9), .INS_W(32), .RESET_PC(9'h1F8)) dut2 (
    .clk(clk), .reset(reset2), .stall(1'b0), .branch_taken(1'b0),
    .branch_target(9'h000), .id_halt(1'b0), .halted(halted2), .bus(bus2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_st(input bit sel, input string tag, input logic [8:0] pc, input logic [8:0] ifpc,
                           input logic [31:0] instr, input logic valid, input logic halt);
    exp_t e;
    e.sel = sel; e.tag = tag; e.pc = pc; e.ifpc = ifpc; e.instr = instr; e.valid = valid; e.halt = halt;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.sel) begin
        chk({e.tag, ".pc"}, 32'(bus2.imem_addr), 32'(e.pc));
        chk({e.tag, ".valid"}, 32'(bus2.if_id_valid), 32'(e.valid));
        chk({e.tag, ".halted"}, 32'(halted2), 32'(e.halt));
      end else begin
        chk({e.tag, ".pc"}, 32'(bus.imem_addr), 32'(e.pc));
        chk({e.tag, ".if_id_pc"}, 32'(bus.if_id_pc), 32'(e.ifpc));
        chk({e.tag, ".instr"}, bus.if_id_instr, e.instr);
        chk({e.tag, ".valid"}, 32'(bus.if_id_valid), 32'(e.valid));
        chk({e.tag, ".halted"}, 32'(halted), 32'(e.halt));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 | 32'(i);
    mem[0] = 32'h00500093;
    mem[1] = 32'h00A00113;
    mem[2] = 32'h002081B3;
    mem[3] = 32'h00000013;
    mem[8] = 32'hFFFFFFFF;
    expect_st(0, "reset", 9'h000, 9'h000, NOP, 0, 0);
    expect_st(1, "reset2", 9'h1F8, 9'h000, NOP, 0, 0);
    tick();
    reset = 0;
    expect_st(0, "run1", 9'h004, 9'h000, 32'h00500093, 1, 0); tick();
    expect_st(0, "run2", 9'h008, 9'h004, 32'h00A00113, 1, 0); tick();
    stall = 1;
    expect_st(0, "stall1", 9'h008, 9'h004, 32'h00A00113, 1, 0); tick();
    expect_st(0, "stall2", 9'h008, 9'h004, 32'h00A00113, 1, 0); tick();
    stall = 0;
    expect_st(0, "release", 9'h00C, 9'h008, 32'h002081B3, 1, 0); tick();
    branch_taken = 1; branch_target = 9'h041; stall = 1; id_halt = 1;
    expect_st(0, "branch_prio", 9'h040, 9'h000, NOP, 0, 0); tick();
    stall = 0; id_halt = 0; branch_target = 9'h020;
    expect_st(0, "branch20", 9'h020, 9'h000, NOP, 0, 0); tick();
    branch_taken = 0;
    expect_st(0, "fetch_halt", 9'h024, 9'h020, 32'hFFFFFFFF, 1, 0); tick();
    id_halt = 1; stall = 1;
    expect_st(0, "halt", 9'h024, 9'h000, NOP, 0, 1); tick();
    id_halt = 0; branch_taken = 1; branch_target = 9'h080;
    expect_st(0, "halted_branch", 9'h024, 9'h000, NOP, 0, 1); tick();
    branch_taken = 0; stall = 0; id_halt = 1;
    expect_st(0, "halted_free", 9'h024, 9'h000, NOP, 0, 1); tick();
    id_halt = 0; reset = 1;
    expect_st(0, "unhalt_reset", 9'h000, 9'h000, NOP, 0, 0); tick();
    reset = 0;
    expect_st(0, "rerun", 9'h004, 9'h000, 32'h00500093, 1, 0); tick();
    reset = 1; stall = 1; branch_taken = 1; branch_target = 9'h040;
    expect_st(0, "reset_prio", 9'h000, 9'h000, NOP, 0, 0); tick();
    reset = 0; stall = 0; branch_taken = 0; reset2 = 0;
    expect_st(0, "after_reset", 9'h004, 9'h000, 32'h00500093, 1, 0);
    expect_st(1, "wrap1", 9'h1FC, 9'h000, 32'h0, 1, 0); tick();
    expect_st(1, "wrap2", 9'h000, 9'h000, 32'h0, 1, 0); tick();
    expect_st(1, "wrap3", 9'h004, 9'h000, 32'h0, 1, 0); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
